// File: rtl/img_buffer.sv
// img_buffer: packs a valid/ready byte stream into one IMG_BITS-wide image word.
// The k-th accepted byte lands at img_out[BYTE_W*k +: BYTE_W]. Once all
// NUM_BYTES beats are in, the image is frozen and img_buffer_full is raised
// until downstream pulses buffer_clear. Beats offered while full are dropped
// and latch the sticky overflow_err flag.
// IMG_BITS must be a multiple of BYTE_W, and NUM_BYTES must fit in byte_count.
module img_buffer #(
  parameter int IMG_BITS = 904,
  parameter int BYTE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                buffer_clear,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  output logic [6:0]          byte_count,
  output logic                overflow_err
);

  localparam int         NUM_BYTES = IMG_BITS / BYTE_W;
  localparam logic [6:0] LAST_IDX  = 7'(NUM_BYTES - 1);

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   last_beat;

  // Handshake and status flags decode only from registers, so there is
  // no combinational path from data_valid or data_in to any output.
  assign data_ready      = (state_q == FILLING);
  assign img_buffer_full = (state_q == FULL);
  assign accept          = data_valid && data_ready;
  assign last_beat       = accept && (byte_count == LAST_IDX);

  // Next-state logic: clear wins over everything, otherwise the final beat
  // moves the buffer to FULL.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    if (buffer_clear) begin
      state_d = FILLING;
    end else if ((state_q == FILLING) && last_beat) begin
      state_d = FULL;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= FILLING;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat counter: clear discards a simultaneous beat; accept is only
  // possible while FILLING, so the count stops at NUM_BYTES and never wraps.
  always_ff @(posedge clk) begin
    if (rst || buffer_clear) begin
      byte_count <= '0;
    end else if (accept) begin
      byte_count <= byte_count + 7'd1;
    end
  end

  // Image register: each accepted byte is written into its own lane; the
  // other lanes keep their contents.
  always_ff @(posedge clk) begin
    // NOTE: this wide register is reset on purpose, because downstream
    // observes img_out = 0 after reset and after clear; a true memory array
    // would normally be left unreset.
    if (rst || buffer_clear) begin
      img_out <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (byte_count == 7'(k)) begin
          img_out[k*BYTE_W +: BYTE_W] <= data_in;
        end
      end
    end
  end

  // Sticky overflow: any beat offered while FULL is dropped and flagged;
  // only rst clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if ((state_q == FULL) && data_valid) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_img_buffer.sv
// Directed testbench for img_buffer. Stimulus pushes each expected completed
// image into a scoreboard queue; a monitor pops and compares it whenever the
// DUT raises img_buffer_full. Status outputs are checked directly at
// chosen points.
module tb_img_buffer;

  localparam int IMG_BITS  = 904;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 113;

  logic                clk = 1'b0;
  logic                rst;
  logic [BYTE_W-1:0]   data_in;
  logic                data_valid;
  logic                data_ready;
  logic                buffer_clear;
  logic [IMG_BITS-1:0] img_out;
  logic                img_buffer_full;
  logic [6:0]          byte_count;
  logic                overflow_err;

  typedef struct {
    logic [IMG_BITS-1:0] img;
    logic [6:0]          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  img_buffer #(.IMG_BITS(IMG_BITS), .BYTE_W(BYTE_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .buffer_clear    (buffer_clear),
    .img_out         (img_out),
    .img_buffer_full (img_buffer_full),
    .byte_count      (byte_count),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG_BITS-1:0] act,
                           input logic [IMG_BITS-1:0] exp);
    int first_bad;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      first_bad = -1;
      for (int k = NUM_BYTES - 1; k >= 0; k--) begin
        if (act[k*BYTE_W +: BYTE_W] !== exp[k*BYTE_W +: BYTE_W]) first_bad = k;
      end
      $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h", name, first_bad,
               act[first_bad*BYTE_W +: BYTE_W], exp[first_bad*BYTE_W +: BYTE_W]);
    end
  endtask

  // Offer one byte on the next cycle; in FILLING it is accepted at that edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = b;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    buffer_clear = 1'b1;
    @(posedge clk);
    #1;
    buffer_clear = 1'b0;
  endtask

  // Monitor: each rising edge of img_buffer_full presents one image.
  initial begin : monitor
    logic full_d;
    exp_t e;
    full_d = 1'b0;
    forever begin
      @(negedge clk);
      if (img_buffer_full === 1'b1 && !full_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_full", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_img("sb_img", img_out, e.img);
          check("sb_count", 32'(byte_count), 32'(e.cnt));
        end
      end
      full_d = (img_buffer_full === 1'b1);
    end
  end

  initial begin : stim
    exp_t e;
    logic [IMG_BITS-1:0] model;

    rst          = 1'b1;
    data_in      = 8'h00;
    data_valid   = 1'b0;
    buffer_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(data_ready), 32'd1);
      check("idle_full", 32'(img_buffer_full), 32'd0);
      check("idle_count", 32'(byte_count), 32'd0);
      check("idle_ovf", 32'(overflow_err), 32'd0);
      check_img("idle_img", img_out, '0);
    end

    // Full fill: byte k = k.
    for (int k = 0; k < NUM_BYTES; k++) model[k*BYTE_W +: BYTE_W] = 8'(k);
    e.img = model; e.cnt = 7'd113;
    exp_q.push_back(e);
    for (int k = 0; k < NUM_BYTES - 1; k++) send_byte(8'(k));
    @(negedge clk);
    check("fill_pre_full", 32'(img_buffer_full), 32'd0);
    check("fill_pre_count", 32'(byte_count), 32'd112);
    send_byte(8'h70);
    @(negedge clk);
    check("fill_full", 32'(img_buffer_full), 32'd1);
    check("fill_ready", 32'(data_ready), 32'd0);
    check("fill_count", 32'(byte_count), 32'd113);
    check("fill_b0", 32'(img_out[7:0]), 32'h00);
    check("fill_b1", 32'(img_out[15:8]), 32'h01);
    check("fill_b112", 32'(img_out[903:896]), 32'h70);

    // Overflow: three beats offered while full.
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = 8'hAA;
    repeat (3) @(negedge clk);
    data_valid = 1'b0;
    data_in    = 8'h00;
    idle(2);
    check("ovf_flag", 32'(overflow_err), 32'd1);
    check("ovf_count", 32'(byte_count), 32'd113);
    check("ovf_full", 32'(img_buffer_full), 32'd1);
    check_img("ovf_img", img_out, model);

    // Clear while full.
    pulse_clear();
    @(negedge clk);
    check("clr_full", 32'(img_buffer_full), 32'd0);
    check("clr_count", 32'(byte_count), 32'd0);
    check("clr_ready", 32'(data_ready), 32'd1);
    check("clr_ovf_sticky", 32'(overflow_err), 32'd1);
    check_img("clr_img", img_out, '0);

    // Gapped fill of 0xFF with random idle gaps.
    e.img = '1; e.cnt = 7'd113;
    exp_q.push_back(e);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k == NUM_BYTES - 1) begin
        @(negedge clk);
        check("gap_pre_full", 32'(img_buffer_full), 32'd0);
        check("gap_pre_count", 32'(byte_count), 32'd112);
      end
      send_byte(8'hFF);
      if (k != NUM_BYTES - 1) begin
        @(negedge clk);
        data_in = 8'h55;
        idle(int'($urandom_range(0, 3)));
      end
    end
    @(negedge clk);
    check("gap_full", 32'(img_buffer_full), 32'd1);
    check("gap_count", 32'(byte_count), 32'd113);
    check_img("gap_img", img_out, '1);

    // Abort: clear in the same cycle as an accepted byte.
    pulse_clear();
    for (int k = 0; k < 50; k++) send_byte(8'(8'h10 + k));
    @(negedge clk);
    check("abort_pre_count", 32'(byte_count), 32'd50);
    data_valid   = 1'b1;
    data_in      = 8'h5A;
    buffer_clear = 1'b1;
    @(posedge clk);
    #1;
    data_valid   = 1'b0;
    buffer_clear = 1'b0;
    @(negedge clk);
    check("abort_count", 32'(byte_count), 32'd0);
    check("abort_full", 32'(img_buffer_full), 32'd0);
    check_img("abort_img", img_out, '0);
    send_byte(8'h3C);
    @(negedge clk);
    check("abort_next_count", 32'(byte_count), 32'd1);
    model = '0;
    model[7:0] = 8'h3C;
    check_img("abort_next_img", img_out, model);

    // Same with rst mid-fill; rst also clears the sticky overflow flag.
    for (int k = 0; k < 39; k++) send_byte(8'(8'h80 + k));
    @(negedge clk);
    check("rst_pre_count", 32'(byte_count), 32'd40);
    data_valid = 1'b1;
    data_in    = 8'h5A;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(byte_count), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_ready", 32'(data_ready), 32'd1);
    check_img("rst_img", img_out, '0);
    send_byte(8'hC3);
    @(negedge clk);
    check("rst_next_count", 32'(byte_count), 32'd1);
    model = '0;
    model[7:0] = 8'hC3;
    check_img("rst_next_img", img_out, model);

    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_buffer.md
Name: img_buffer

Overview:
- Upstream neighbour of the BNN interface stage. Collects a serial byte stream and packs it into one 904-bit image word (30x30 = 900 pixel bits + 4 pad bits).
- Raises img_buffer_full for the BNN control FSM and holds the image stable until the downstream side clears it.
- Byte source is a valid/ready producer, e.g. the SPI/UART receiver.

Parameters:
- IMG_BITS, 904, width of packed image word; must be a multiple of BYTE_W.
- BYTE_W, 8, width of each incoming data beat.
- NUM_BYTES, IMG_BITS/BYTE_W (113), beats per image; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- data_in  input  BYTE_W  incoming byte
- data_valid  input  1  data_in valid this cycle
- data_ready  output  1  buffer can accept a byte this cycle
- buffer_clear  input  1  one-cycle pulse from downstream: image consumed, empty buffer
- img_out  output  IMG_BITS  packed image, stable while img_buffer_full=1
- img_buffer_full  output  1  all NUM_BYTES bytes captured
- byte_count  output  7  bytes captured so far in current image (0..NUM_BYTES)
- overflow_err  output  1  sticky: data_valid seen while full

Behaviour:
- Reset (rst=1 at a clk edge), all registered:
  - state=FILLING, byte_count=0, img_out=0, img_buffer_full=0, overflow_err=0.
  - data_ready is 1 on the first cycle after reset deasserts.
- data_ready = (state==FILLING); decoded from the state register only, never from data_valid.
- Accept = data_valid && data_ready at a clk edge.
- Packing: the k-th accepted byte (k=0..NUM_BYTES-1) is written to img_out[BYTE_W*k+BYTE_W-1 : BYTE_W*k]. Other bits are unchanged.
- FILLING:
  - On accept with byte_count < NUM_BYTES-1: write the byte, byte_count += 1.
  - On accept with byte_count == NUM_BYTES-1:
    - write the byte, byte_count = NUM_BYTES, state -> FULL.
    - img_buffer_full=1 from the next cycle, i.e. one cycle after the last byte edge.
- FULL:
  - data_ready=0; img_out and byte_count held.
  - data_valid=1 sets overflow_err=1; the byte is dropped.
  - overflow_err clears only on rst.
- buffer_clear, in any state:
  - next cycle: state=FILLING, byte_count=0, img_out=0, img_buffer_full=0.
  - Clear while FILLING aborts the partial image.
  - Clear has priority over a simultaneous accept: that byte is discarded and is not counted as byte 0.
- rst during FILLING or FULL: identical to the reset values above. Partial data is lost.
- byte_count width is 7 bits and never wraps. The max value is NUM_BYTES; increment is blocked once FULL.
- No combinational path from data_in to any output.

Test Plan:
- Reset then idle: after rst pulse, data_ready=1, img_buffer_full=0, byte_count=0, img_out=0 held for 20 cycles with data_valid=0.
- Full fill:
  - Stimulus: 113 back-to-back bytes, value = byte index (0x00..0x70).
  - Required: img_buffer_full=1 exactly one cycle after the 113th accept, data_ready=0.
  - Required: img_out[7:0]=0x00, img_out[15:8]=0x01, img_out[903:896]=0x70, byte_count=113.
- Gapped fill: 113 bytes of 0xFF with data_valid toggling 1/0 and random gaps -> only valid cycles counted; full after exactly 113 accepts; img_out all ones.
- Overflow: after full, drive data_valid=1 with data_in=0xAA for 3 cycles -> overflow_err=1 (sticky), img_out unchanged, byte_count=113.
- Clear:
  - Stimulus: buffer_clear pulse while full.
  - Required: next cycle img_buffer_full=0, byte_count=0, img_out=0, data_ready=1. A new 113-byte image then fills correctly.
- Abort / simultaneous events:
  - Stimulus: after 50 bytes, assert buffer_clear in the same cycle as an accepted byte 0x5A.
  - Required: byte_count=0, img_out=0; the following byte lands in img_out[7:0].
  - Repeat with rst instead of buffer_clear mid-fill: same result, and overflow_err=0.
